// File: rtl/coherence_controller.sv
// -----------------------------------------------------------------------------
// coherence_controller
//
// Bus controller for CPUS private caches sharing one RAM port. It arbitrates
// icache fetches, dcache evictions and dcache misses, and keeps the dcaches
// coherent with a snoop/invalidate protocol. A miss is first broadcast as a
// snoop to every other cache. If any snooped cache holds the line dirty, it
// supplies the data cache-to-cache, and RAM is updated in the same beat.
// Otherwise the line is read from RAM.
//
// Ports (c = CPU index, every *_W-wide vector is packed as CPUS slices):
//   CLK, RST              clock (rising edge), asynchronous active-high reset
//   iREN/iaddr            icache read request/address
//   iwait/iload           icache stall (low one cycle = iload valid) / data
//   dREN/dWEN/daddr/dstore dcache read/write request, address, write data
//   dwait/dload           dcache stall (low one cycle = beat done) / data
//   cctrans/ccwrite       requester: miss active / exclusive intent
//                         snooped:   snoop ack / line dirty
//   ccwait/ccinv          snoop in progress / invalidate snooped line
//   ccsnoopaddr           snooped line address
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ramwait   single RAM port
//
// Build option: define CC_RR_EN for round-robin arbitration within a
// request class. Without it, the lowest CPU index wins.
//
// Outputs are combinational on the registered state and grant. A RAM beat
// therefore completes in the same cycle that ramwait is low.
// -----------------------------------------------------------------------------
module coherence_controller #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32,
    parameter int PTR_W  = (CPUS > 1) ? $clog2(CPUS) : 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [CPUS-1:0]        iREN,
    input  logic [CPUS*WORD_W-1:0] iaddr,
    output logic [CPUS-1:0]        iwait,
    output logic [CPUS*WORD_W-1:0] iload,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS*WORD_W-1:0] daddr,
    input  logic [CPUS*WORD_W-1:0] dstore,
    output logic [CPUS-1:0]        dwait,
    output logic [CPUS*WORD_W-1:0] dload,
    input  logic [CPUS-1:0]        cctrans,
    input  logic [CPUS-1:0]        ccwrite,
    output logic [CPUS-1:0]        ccwait,
    output logic [CPUS-1:0]        ccinv,
    output logic [CPUS*WORD_W-1:0] ccsnoopaddr,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic                   ramwait
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_SNOOP,
        ST_C2C,
        ST_LOAD,
        ST_IFETCH
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] grant_q, grant_d;
    logic [PTR_W-1:0] supplier_q, supplier_d;
    logic [PTR_W-1:0] arb_start;
    logic [CPUS-1:0]  ack_q, ack_d;
    logic [CPUS-1:0]  dirty_q, dirty_d;
    logic [CPUS-1:0]  others;
    logic [CPUS-1:0]  evict_req, miss_req;
    logic [CPUS-1:0]  ack_now, dirty_now;
    logic             snoop_done;
    logic             c2c_beat;

    logic [WORD_W-1:0] iaddr_w  [CPUS];
    logic [WORD_W-1:0] daddr_w  [CPUS];
    logic [WORD_W-1:0] dstore_w [CPUS];
    logic [WORD_W-1:0] iload_w  [CPUS];
    logic [WORD_W-1:0] dload_w  [CPUS];
    logic [WORD_W-1:0] snoop_w  [CPUS];

    for (genvar c = 0; c < CPUS; c++) begin : g_slice
        assign iaddr_w[c]  = iaddr[c*WORD_W +: WORD_W];
        assign daddr_w[c]  = daddr[c*WORD_W +: WORD_W];
        assign dstore_w[c] = dstore[c*WORD_W +: WORD_W];
        assign iload[c*WORD_W +: WORD_W]       = iload_w[c];
        assign dload[c*WORD_W +: WORD_W]       = dload_w[c];
        assign ccsnoopaddr[c*WORD_W +: WORD_W] = snoop_w[c];
    end

    // Search req starting at index start, wrapping around; first hit wins.
    function automatic logic [PTR_W-1:0] pick(input logic [CPUS-1:0]  req,
                                              input logic [PTR_W-1:0] start);
        logic [PTR_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < CPUS; k++) begin
            idx = (int'(start) + k) % CPUS;
            if (!found && req[idx]) begin
                sel   = PTR_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        others = '0;
        for (int c = 0; c < CPUS; c++) begin
            others[c] = (PTR_W'(c) != grant_q);
        end
    end

    assign evict_req = dWEN & ~cctrans;
    assign miss_req  = dREN & cctrans;

    // Acks may trickle in over several cycles, so they are accumulated. With
    // a single CPU there are no peers and the snoop completes immediately.
    assign ack_now    = ack_q | (cctrans & others);
    assign dirty_now  = dirty_q | (cctrans & ccwrite & others);
    assign snoop_done = &(ack_now | ~others);

`ifdef CC_RR_EN
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             txn_done;

    assign arb_start = rr_ptr_q;
    always_comb begin
        txn_done = (state_q != ST_IDLE) && (state_d == ST_IDLE);
        rr_ptr_d = txn_done ? PTR_W'((int'(grant_q) + 1) % CPUS) : rr_ptr_q;
    end
`else
    assign arb_start = '0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        supplier_d = supplier_q;
        ack_d      = ack_q;
        dirty_d    = dirty_q;
        case (state_q)
            ST_IDLE: begin
                ack_d   = '0;
                dirty_d = '0;
                if (|evict_req) begin
                    grant_d = pick(evict_req, arb_start);
                    state_d = ST_WB;
                end else if (|miss_req) begin
                    grant_d = pick(miss_req, arb_start);
                    state_d = ST_SNOOP;
                end else if (|iREN) begin
                    grant_d = pick(iREN, arb_start);
                    state_d = ST_IFETCH;
                end
            end
            ST_WB: begin
                if (!dWEN[grant_q]) state_d = ST_IDLE;
            end
            ST_SNOOP: begin
                ack_d   = ack_now;
                dirty_d = dirty_now;
                if (snoop_done) begin
                    if (|dirty_now) begin
                        supplier_d = pick(dirty_now, '0);
                        state_d    = ST_C2C;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_C2C, ST_LOAD: begin
                if (!cctrans[grant_q]) state_d = ST_IDLE;
            end
            ST_IFETCH: begin
                if (!ramwait) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            supplier_q <= '0;
            ack_q      <= '0;
            dirty_q    <= '0;
`ifdef CC_RR_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            supplier_q <= supplier_d;
            ack_q      <= ack_d;
            dirty_q    <= dirty_d;
`ifdef CC_RR_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    always_comb begin
        iwait    = '1;
        dwait    = '1;
        ccwait   = '0;
        ccinv    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        c2c_beat = 1'b0;
        for (int c = 0; c < CPUS; c++) begin
            iload_w[c] = '0;
            dload_w[c] = '0;
            snoop_w[c] = '0;
        end
        case (state_q)
            ST_WB: begin
                // Strobe only while a word is offered, so the cycle in which
                // dWEN drops does not write stale data.
                ramWEN          = dWEN[grant_q];
                ramaddr         = daddr_w[grant_q];
                ramstore        = dstore_w[grant_q];
                dwait[grant_q]  = ramwait | ~dWEN[grant_q];
            end
            ST_SNOOP: begin
                for (int c = 0; c < CPUS; c++) begin
                    if (others[c]) begin
                        ccwait[c]  = 1'b1;
                        ccinv[c]   = ccwrite[grant_q];
                        snoop_w[c] = daddr_w[grant_q];
                    end
                end
            end
            ST_C2C: begin
                // Each supplier word goes to the requester and to RAM in one beat.
                c2c_beat            = dWEN[supplier_q] & ~ramwait;
                ccwait[supplier_q]  = 1'b1;
                snoop_w[supplier_q] = daddr_w[grant_q];
                ramWEN              = dWEN[supplier_q];
                ramaddr             = daddr_w[supplier_q];
                ramstore            = dstore_w[supplier_q];
                dload_w[grant_q]    = dstore_w[supplier_q];
                dwait[supplier_q]   = ~c2c_beat;
                dwait[grant_q]      = ~c2c_beat;
            end
            ST_LOAD: begin
                ramREN           = 1'b1;
                ramaddr          = daddr_w[grant_q];
                dload_w[grant_q] = ramload;
                dwait[grant_q]   = ramwait;
            end
            ST_IFETCH: begin
                ramREN           = 1'b1;
                ramaddr          = iaddr_w[grant_q];
                iload_w[grant_q] = ramload;
                iwait[grant_q]   = ramwait;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_controller.sv
// -----------------------------------------------------------------------------
// Bench for coherence_controller (2 CPUs). CPU caches and RAM are scripted by
// tasks. ramwait runs free with random latency. Expected data comes from a
// word-addressed memory model that is updated by the intended transactions
// (evictions, cache-to-cache transfers), plus a transaction-level arbitration
// model.
// -----------------------------------------------------------------------------
module tb_coherence_controller;
    localparam int CPUS = 2;
    localparam int W    = 32;
`ifdef CC_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                CLK = 1'b0;
    logic                RST;
    logic [CPUS-1:0]     iREN, iwait, dREN, dWEN, dwait;
    logic [CPUS-1:0]     cctrans, ccwrite, ccwait, ccinv;
    logic [CPUS*W-1:0]   iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
    logic                ramREN, ramWEN, ramwait;
    logic [W-1:0]        ramaddr, ramstore, ramload;

    int checks   = 0;
    int failures = 0;
    int ram_lat  = 0;
    int model_rr = 0;

    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    coherence_controller #(.CPUS(CPUS), .WORD_W(W)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramwait(ramwait)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected bench completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] sl(input logic [CPUS*W-1:0] v, input int c);
        return v[c*W +: W];
    endfunction

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
        iaddr = '0; daddr = '0; dstore = '0;
    endtask

    // Move to just after the next rising edge; inputs may then be driven.
    task automatic advance();
        @(posedge CLK);
        #1;
        if (ram_lat > 0) begin
            ram_lat--;
            ramwait = 1'b1;
        end else begin
            ramwait = 1'b0;
            ram_lat = $urandom_range(0, 2);
        end
    endtask

    // Let combinational outputs settle, serve RAM reads, commit RAM writes.
    task automatic settle();
        #1;
        ramload = ramREN ? ram_rd(ramaddr) : 32'h0;
        #1;
        check_eq("ram_ren_wen_excl", 32'(ramREN & ramWEN), 32'd0);
        if (ramWEN && !ramwait) ram_mem[ramaddr] = ramstore;
    endtask

    task automatic check_idle();
        check_eq("idle_iwait", 32'(iwait), 32'd3);
        check_eq("idle_dwait", 32'(dwait), 32'd3);
        check_eq("idle_ccwait", 32'(ccwait), 32'd0);
        check_eq("idle_ramren", 32'(ramREN), 32'd0);
        check_eq("idle_ramwen", 32'(ramWEN), 32'd0);
    endtask

    task automatic finish_txn();
        settle();
        advance();
        settle();
        check_idle();
        advance();
    endtask

    task automatic do_ifetch(input int c, input logic [31:0] a);
        bit got;
        got = 1'b0;
        iREN[c] = 1'b1;
        iaddr[c*W +: W] = a;
        for (int n = 0; n < 60 && !got; n++) begin
            settle();
            if (!iwait[c]) begin
                check_eq("ifetch_data", sl(iload, c), ref_rd(a));
                check_eq("ifetch_ramaddr", ramaddr, a);
                check_eq("ifetch_other_iwait", 32'(iwait[1-c]), 32'd1);
                got = 1'b1;
            end
            advance();
        end
        if (!got) check_eq("ifetch_timeout", 32'd0, 32'd1);
        iREN[c] = 1'b0;
        model_rr = (c + 1) % CPUS;
        finish_txn();
    endtask

    task automatic do_miss(input int g, input logic [31:0] a, input bit excl, input bit dirty,
                           input logic [31:0] d0, input logic [31:0] d1);
        int          o;
        int          dly;
        bit          got;
        logic [31:0] wa;
        logic [31:0] dat [2];
        o = 1 - g;
        dat[0] = d0;
        dat[1] = d1;
        dREN[g] = 1'b1; cctrans[g] = 1'b1; ccwrite[g] = excl;
        daddr[g*W +: W] = a;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            settle();
            if (ccwait[o]) begin
                check_eq("snoop_inv", 32'(ccinv[o]), 32'(excl));
                check_eq("snoop_addr", sl(ccsnoopaddr, o), a);
                check_eq("snoop_req_dwait", 32'(dwait[g]), 32'd1);
                check_eq("snoop_req_ccwait", 32'(ccwait[g]), 32'd0);
                got = 1'b1;
            end
            advance();
        end
        if (!got) check_eq("snoop_timeout", 32'd0, 32'd1);
        dly = $urandom_range(0, 2);
        for (int n = 0; n < dly; n++) begin
            settle();
            check_eq("snoop_hold_ccwait", 32'(ccwait[o]), 32'd1);
            check_eq("snoop_hold_dwait", 32'(dwait[g]), 32'd1);
            advance();
        end
        cctrans[o] = 1'b1;
        ccwrite[o] = dirty;
        dWEN[o]    = dirty;
        for (int i = 0; i < 2; i++) begin
            wa = a + 32'(4 * i);
            daddr[g*W +: W] = wa;
            if (dirty) begin
                daddr[o*W +: W]  = wa;
                dstore[o*W +: W] = dat[i];
            end
            got = 1'b0;
            for (int n = 0; n < 60 && !got; n++) begin
                settle();
                if (!dwait[g]) begin
                    if (dirty) begin
                        check_eq("c2c_dload", sl(dload, g), dat[i]);
                        check_eq("c2c_supplier_dwait", 32'(dwait[o]), 32'd0);
                        check_eq("c2c_ramwen", 32'(ramWEN), 32'd1);
                        check_eq("c2c_ramaddr", ramaddr, wa);
                        ref_mem[wa] = dat[i];
                    end else begin
                        check_eq("load_dload", sl(dload, g), ref_rd(wa));
                        check_eq("load_ramren", 32'(ramREN), 32'd1);
                    end
                    got = 1'b1;
                end
                advance();
            end
            if (!got) check_eq("miss_word_timeout", 32'd0, 32'd1);
        end
        dREN[g] = 1'b0; cctrans = '0; ccwrite = '0; dWEN[o] = 1'b0;
        model_rr = (g + 1) % CPUS;
        finish_txn();
    endtask

    task automatic do_evict(input int c, input logic [31:0] a, input logic [31:0] d0,
                            input logic [31:0] d1, input int if_cpu, input logic [31:0] if_addr);
        bit          got;
        logic [31:0] wa;
        logic [31:0] dat [2];
        dat[0] = d0;
        dat[1] = d1;
        if (if_cpu >= 0) begin
            iREN[if_cpu] = 1'b1;
            iaddr[if_cpu*W +: W] = if_addr;
        end
        for (int i = 0; i < 2; i++) begin
            wa = a + 32'(4 * i);
            dWEN[c] = 1'b1;
            daddr[c*W +: W]  = wa;
            dstore[c*W +: W] = dat[i];
            got = 1'b0;
            for (int n = 0; n < 60 && !got; n++) begin
                settle();
                if (if_cpu >= 0) check_eq("wb_before_ifetch", 32'(iwait[if_cpu]), 32'd1);
                if (!dwait[c]) begin
                    check_eq("wb_ramwen", 32'(ramWEN), 32'd1);
                    check_eq("wb_ramaddr", ramaddr, wa);
                    check_eq("wb_ramstore", ramstore, dat[i]);
                    ref_mem[wa] = dat[i];
                    got = 1'b1;
                end
                advance();
            end
            if (!got) check_eq("wb_timeout", 32'd0, 32'd1);
        end
        dWEN[c] = 1'b0;
        model_rr = (c + 1) % CPUS;
        if (if_cpu >= 0) do_ifetch(if_cpu, if_addr);
        else finish_txn();
    endtask

    task automatic do_arb(input int n_fetch);
        logic [31:0] a [2];
        int          served;
        int          exp_c;
        bit          got;
        a[0] = 32'h300;
        a[1] = 32'h380;
        iREN = 2'b11;
        iaddr[0 +: W] = a[0];
        iaddr[W +: W] = a[1];
        for (int k = 0; k < n_fetch; k++) begin
            got = 1'b0;
            served = 0;
            for (int n = 0; n < 60 && !got; n++) begin
                settle();
                if (iwait != 2'b11) begin
                    check_eq("arb_single_grant", 32'(iwait[0] ^ iwait[1]), 32'd1);
                    served = iwait[0] ? 1 : 0;
                    got = 1'b1;
                end
                advance();
            end
            if (!got) begin
                check_eq("arb_timeout", 32'd0, 32'd1);
            end else begin
                exp_c = RR ? model_rr : 0;
                check_eq("arb_grant", 32'(served), 32'(exp_c));
                model_rr = (served + 1) % CPUS;
            end
        end
        iREN = '0;
        finish_txn();
    endtask

    task automatic do_reset_mid_c2c(input logic [31:0] a);
        bit got;
        dREN[0] = 1'b1; cctrans[0] = 1'b1; ccwrite[0] = 1'b1;
        daddr[0 +: W] = a;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            settle();
            if (ccwait[1]) got = 1'b1;
            advance();
        end
        if (!got) check_eq("rst_snoop_timeout", 32'd0, 32'd1);
        // Supplier data equals current memory so a beat before reset is harmless.
        cctrans[1] = 1'b1; ccwrite[1] = 1'b1; dWEN[1] = 1'b1;
        daddr[W +: W]  = a;
        dstore[W +: W] = ref_rd(a);
        settle();
        advance();
        settle();
        check_eq("rst_c2c_entered", 32'(ramWEN), 32'd1);
        check_eq("rst_c2c_dload", sl(dload, 0), ref_rd(a));
        #1 RST = 1'b1;
        #1;
        check_eq("rst_iwait", 32'(iwait), 32'd3);
        check_eq("rst_dwait", 32'(dwait), 32'd3);
        check_eq("rst_ccwait", 32'(ccwait), 32'd0);
        check_eq("rst_ccinv", 32'(ccinv), 32'd0);
        check_eq("rst_ramwen", 32'(ramWEN), 32'd0);
        check_eq("rst_ramren", 32'(ramREN), 32'd0);
        clear_inputs();
        advance();
        RST = 1'b0;
        model_rr = 0;
        settle();
        check_idle();
        advance();
    endtask

    initial begin
        int          kind;
        int          c;
        logic [31:0] a;
        RST = 1'b1;
        clear_inputs();
        ramwait = 1'b1;
        ramload = '0;
        ram_mem[32'h40] = 32'hDEAD_BEEF;
        ref_mem[32'h40] = 32'hDEAD_BEEF;
        #12;
        check_eq("reset_iwait", 32'(iwait), 32'd3);
        check_eq("reset_dwait", 32'(dwait), 32'd3);
        check_eq("reset_ccwait", 32'(ccwait), 32'd0);
        check_eq("reset_ccinv", 32'(ccinv), 32'd0);
        check_eq("reset_snoopaddr", 32'(|ccsnoopaddr), 32'd0);
        check_eq("reset_loads", 32'(|{iload, dload}), 32'd0);
        check_eq("reset_ramstrobe", 32'({ramREN, ramWEN}), 32'd0);
        check_eq("reset_ramaddr", ramaddr, 32'd0);
        check_eq("reset_ramstore", ramstore, 32'd0);
        advance();
        RST = 1'b0;

        do_ifetch(0, 32'h40);
        do_miss(1, 32'h100, 1'b1, 1'b0, 32'h0, 32'h0);
        do_miss(0, 32'h200, 1'b0, 1'b1, 32'h11, 32'h22);
        do_evict(1, 32'h500, $urandom, $urandom, 0, 32'h200);
        do_arb(4);

        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 2);
            c    = $urandom_range(0, 1);
            a    = 32'($urandom_range(0, 31)) << 3;
            case (kind)
                0: do_ifetch(c, a + 32'(4 * $urandom_range(0, 1)));
                1: do_miss(c, a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           $urandom, $urandom);
                default: do_evict(c, a, $urandom, $urandom,
                                  ($urandom_range(0, 1) != 0) ? 1 - c : -1,
                                  32'($urandom_range(0, 63)) << 2);
            endcase
        end

        do_reset_mid_c2c(32'h200);
        do_arb(3);

        foreach (ref_mem[k]) check_eq("mem_final", ram_rd(k), ref_mem[k]);
        foreach (ram_mem[k]) check_eq("mem_no_stray", ram_mem[k], ref_rd(k));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
